// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
    localparam logic [1:0] PCSEL_ALU   = 2'd1;

    typedef enum logic [1:0] {
        FETCH_BOOT       = 2'd0,
        FETCH_RUN        = 2'd1,
        FETCH_REDIR_PEND = 2'd2
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and decode-side signals of the fetch stage.
interface fetch_stage_if;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] alu_out;
    logic        inst_kill;
    logic [31:0] imem_dout;
    logic [31:0] imem_addr;
    logic        imem_re;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [31:0] fetch_count;

    modport slave (
        input  stall, pc_sel, alu_out, inst_kill, imem_dout,
        output imem_addr, imem_re, inst, inst_pc, inst_valid, fetch_count
    );

    modport master (
        output stall, pc_sel, alu_out, inst_kill, imem_dout,
        input  imem_addr, imem_re, inst, inst_pc, inst_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage_counter.sv
// 32-bit wrapping event counter with enable; counts instructions accepted downstream.
module fetch_counter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [31:0] o_count
);
    logic [31:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_count <= '0;
        else if (i_en) r_count <= r_count + 32'd1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the sync-read imem, handles
// redirects, stalls (with a pending-redirect slot) and kill bubbles.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.slave bus
);
    fetch_state_e r_state;
    fetch_state_e w_state_nx;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pend_nx;
    logic [31:0]  w_target;
    logic         w_redirect;
    logic         w_bubble;
    logic         w_inst_valid;

    assign w_redirect = (bus.pc_sel == PCSEL_ALU);
    assign w_target   = align_word(bus.alu_out);

    always_comb begin
        w_state_nx = r_state;
        w_pc_next  = r_pc + 32'd4;
        w_pend_nx  = r_pend;
        w_bubble   = 1'b1;
        case (r_state)
            FETCH_BOOT: begin
                w_pc_next  = RESET_PC;
                w_state_nx = FETCH_RUN;
            end
            FETCH_RUN: begin
                w_bubble = 1'b0;
                if (w_redirect && !bus.stall) begin
                    w_pc_next = w_target;
                end else if (bus.stall) begin
                    // Re-present the same address so the stalled word stays on imem_dout.
                    w_pc_next = r_pc;
                    if (w_redirect) begin
                        w_pend_nx  = w_target;
                        w_state_nx = FETCH_REDIR_PEND;
                    end
                end
            end
            FETCH_REDIR_PEND: begin
                if (bus.stall) begin
                    w_pc_next = r_pc;
                    if (w_redirect) w_pend_nx = w_target;
                end else begin
                    w_pc_next  = w_redirect ? w_target : r_pend;
                    w_state_nx = FETCH_RUN;
                end
            end
            default: begin
                w_pc_next  = RESET_PC;
                w_state_nx = FETCH_BOOT;
            end
        endcase
        if (bus.inst_kill) w_bubble = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH_BOOT;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_next;
            r_pend  <= w_pend_nx;
        end
    end

    assign w_inst_valid   = ~w_bubble;
    assign bus.imem_addr  = w_pc_next;
    assign bus.imem_re    = reset;
    assign bus.inst       = w_bubble ? NOP_INST : bus.imem_dout;
    assign bus.inst_pc    = r_pc;
    assign bus.inst_valid = w_inst_valid;

    fetch_counter u_fetch_counter (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_inst_valid & ~bus.stall),
        .o_count (bus.fetch_count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed sequence then random traffic
// against a transaction-level PC/pending-redirect model.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
    endfunction

    always @(posedge clk) bus.imem_dout <= mem_word(bus.imem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: PC of the presented instruction, boot flag, optional pending target.
    bit          m_boot;
    bit          m_pend_v;
    logic [31:0] m_pc, m_pend, m_cnt;
    logic [31:0] l_inst, l_pc, l_addr, l_cnt;
    logic        l_valid;

    task automatic model_init();
        m_boot = 1'b1; m_pend_v = 1'b0; m_pc = RST_PC; m_pend = '0; m_cnt = '0;
    endtask

    task automatic step(input logic s, input logic [1:0] ps, input logic [31:0] alu, input logic k);
        logic [31:0] tgt, e_addr, e_inst;
        logic        redir, e_valid;
        bus.stall = s; bus.pc_sel = ps; bus.alu_out = alu; bus.inst_kill = k;
        #3;
        redir   = (ps == 2'd1);
        tgt     = {alu[31:2], 2'b00};
        e_valid = !m_boot && !m_pend_v && !k;
        e_inst  = e_valid ? mem_word(m_pc) : NOP;
        if (m_boot)        e_addr = RST_PC;
        else if (s)        e_addr = m_pc;
        else if (redir)    e_addr = tgt;
        else if (m_pend_v) e_addr = m_pend;
        else               e_addr = m_pc + 32'd4;
        chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, e_valid});
        chk("inst", bus.inst, e_inst);
        chk("inst_pc", bus.inst_pc, m_pc);
        chk("imem_addr", bus.imem_addr, e_addr);
        chk("imem_re", {31'b0, bus.imem_re}, 32'd1);
        chk("fetch_count", bus.fetch_count, m_cnt);
        l_inst = bus.inst; l_pc = bus.inst_pc; l_addr = bus.imem_addr;
        l_cnt = bus.fetch_count; l_valid = bus.inst_valid;
        if (e_valid && !s) m_cnt = m_cnt + 32'd1;
        if (m_boot)             m_boot = 1'b0;
        else if (m_pend_v) begin
            if (!s)             m_pend_v = 1'b0;
            else if (redir)     m_pend = tgt;
        end else if (redir && s) begin
            m_pend_v = 1'b1; m_pend = tgt;
        end
        m_pc = e_addr;
        @(posedge clk); #1;
    endtask

    // Assert reset mid-cycle, check immediate reset values, release one cycle later.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_inst", bus.inst, NOP);
        chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, RST_PC);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst_imem_re", {31'b0, bus.imem_re}, 32'd0);
        chk("rst_fetch_count", bus.fetch_count, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        model_init();
    endtask

    initial begin
        logic [31:0] alu;
        bus.stall = 0; bus.pc_sel = 0; bus.alu_out = 0; bus.inst_kill = 0;
        reset = 1'b1;
        #1;
        do_reset();

        step(0, 2'd0, 0, 0);
        chk("tp_c0_valid", {31'b0, l_valid}, 32'd0);
        chk("tp_c0_inst", l_inst, NOP);
        step(0, 2'd0, 0, 0);
        chk("tp_c1_inst", l_inst, 32'h0050_0093);
        chk("tp_c1_pc", l_pc, RST_PC);
        step(0, 2'd0, 0, 0);
        chk("tp_c2_pc", l_pc, 32'h4000_0004);
        repeat (3) begin
            step(1, 2'd0, 0, 0);
            chk("tp_stall_pc", l_pc, 32'h4000_0008);
            chk("tp_stall_cnt", l_cnt, 32'd2);
        end
        step(0, 2'd0, 0, 0);
        chk("tp_unstall_pc", l_pc, 32'h4000_0008);
        step(0, 2'd1, 32'h4000_0103, 0);
        chk("tp_resume_pc", l_pc, 32'h4000_000C);
        chk("tp_redir_addr", l_addr, 32'h4000_0100);
        step(1, 2'd1, 32'h4000_0200, 0);
        chk("tp_redir_pc", l_pc, 32'h4000_0100);
        step(1, 2'd1, 32'h4000_0300, 0);
        chk("tp_pend_bubble0", {31'b0, l_valid}, 32'd0);
        step(1, 2'd0, 0, 0);
        chk("tp_pend_bubble1", {31'b0, l_valid}, 32'd0);
        step(0, 2'd0, 0, 0);
        chk("tp_pend_bubble2", {31'b0, l_valid}, 32'd0);
        chk("tp_pend_addr", l_addr, 32'h4000_0300);
        step(0, 2'd0, 0, 0);
        chk("tp_pend_pc", l_pc, 32'h4000_0300);
        step(0, 2'd0, 0, 1);
        chk("tp_kill_inst", l_inst, NOP);
        chk("tp_kill_valid", {31'b0, l_valid}, 32'd0);
        step(0, 2'd0, 0, 0);
        chk("tp_kill_pc", l_pc, 32'h4000_0308);
        // Exercise 32-bit PC wrap.
        step(0, 2'd1, 32'hFFFF_FFFF, 0);
        step(0, 2'd0, 0, 0);
        step(0, 2'd0, 0, 0);
        chk("wrap_pc", l_pc, 32'h0000_0000);
        step(1, 2'd1, 32'h4000_0500, 0);
        step(1, 2'd0, 0, 0);
        do_reset();
        step(0, 2'd0, 0, 0);
        step(0, 2'd0, 0, 0);
        chk("tp_rst_pc", l_pc, RST_PC);
        chk("tp_rst_cnt", l_cnt, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            case ($urandom_range(0, 3))
                0:       alu = RST_PC + $urandom_range(0, 4095);
                1:       alu = 32'hFFFF_FF00 + $urandom_range(0, 255);
                default: alu = $urandom;
            endcase
            step($urandom_range(0, 2) == 0,
                 ($urandom_range(0, 3) == 0) ? 2'd1 : 2'($urandom_range(0, 3) & 2'd2),
                 alu,
                 $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the Riscv151 three-stage pipeline, directly upstream of the decode/control stage. Owns the PC register and drives the synchronous-read instruction memory. Applies redirects from the X stage, holds during stalls, and injects NOP bubbles on kill. Delivers `inst`, `inst_pc` and `inst_valid` to the control and datapath.

## Interface
- `RESET_PC`, 32'h4000_0000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: bubble encoding (addi x0,x0,0).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  downstream cannot accept the current I-stage instruction this cycle.
- `pc_sel`  in  2  `PCSEL_PLUS4` / `PCSEL_ALU` from control.
- `alu_out`  in  32  redirect target (branch/jump), byte address.
- `inst_kill`  in  1  current I-stage instruction is wrong-path.
- `imem_dout`  in  32  instruction memory read data, valid 1 cycle after address.
- `imem_addr`  out  32  byte address to instruction memory (combinational `pc_next`).
- `imem_re`  out  1  memory read enable.
- `inst`  out  32  I-stage instruction to decode.
- `inst_pc`  out  32  PC of `inst`.
- `inst_valid`  out  1  `inst` is real and not killed.
- `fetch_count`  out  32  count of instructions accepted downstream.

## Operation
- Registers: `pc_q` (PC of the I-stage instruction), `pend_q` (pending redirect target), `state`, and `fetch_count`.
- Redirect: `redirect = (pc_sel == PCSEL_ALU)`. The target is `{alu_out[31:2], 2'b00}`.
- States:
  - BOOT: first cycle after reset release.
    - `pc_next = RESET_PC`, output is the bubble.
    - Always → RUN.
  - RUN: `pc_next` priority is redirect&!stall → target; stall → `pc_q`; else `pc_q+4`.
    - If redirect&stall: `pend_q <= target`, go to REDIR_PEND, `pc_next = pc_q`.
  - REDIR_PEND: if stall, hold `pc_next = pc_q`; a new redirect overwrites `pend_q` (latest wins).
    - If !stall: `pc_next` = redirect ? target : `pend_q`, then → RUN.
    - Output is the bubble in every REDIR_PEND cycle.
- `pc_q <= pc_next` every cycle; `imem_addr = pc_next`.
- `inst = imem_dout`, `inst_pc = pc_q`, `inst_valid = 1` in RUN.
- Bubble: `inst = NOP_INST`, `inst_valid = 0`, `inst_pc = pc_q`.
- `inst_kill` forces the bubble in any state. It does not alter `pc_next` or the state.
- Stall in RUN re-presents `pc_q`, so the memory re-reads the same word and `inst`/`inst_pc` stay stable.
- `fetch_count` increments when `inst_valid && !stall`. It wraps modulo 2^32.
- PC arithmetic is 32-bit unsigned; `pc_q+4` wraps at 2^32.
- `imem_re` is 0 while `reset` is low, 1 otherwise.

## Timing
- Reset values while `reset` is low, taking effect immediately:
  - `state` = BOOT, `pc_q` = `RESET_PC`, `pend_q` = 0, `fetch_count` = 0.
  - `inst` = `NOP_INST`, `inst_pc` = `RESET_PC`, `inst_valid` = 0.
  - `imem_addr` = `RESET_PC`, `imem_re` = 0.
- First valid instruction: cycle 1 after reset release (BOOT is cycle 0), with `inst_pc` = `RESET_PC`.
- Redirect latency: a redirect in cycle t (no stall) puts the target instruction on `inst` in cycle t+1.
- Redirect during stall: the target appears 1 cycle after the first non-stall cycle.
- Stall: outputs identical in every stalled RUN cycle; sequential fetch resumes 1 cycle after stall drops.
- `inst_kill` acts combinationally in the same cycle (the only input-to-output comb path besides `pc_sel`/`alu_out`/`stall` → `imem_addr`).
- Reset mid-stall or mid-REDIR_PEND discards `pend_q`; the next release restarts at BOOT.

## Structure
- Shared header `const.vh` holds:
  - the `PCSEL_*` codes;
  - `NOP_INST`;
  - state encodings `FETCH_BOOT`, `FETCH_RUN`, `FETCH_REDIR_PEND`.
- Flops are built from the codebase's async-reset register primitive with active-low reset.
- One sub-module: `fetch_counter`, a 32-bit wrapping counter with enable and async active-low reset.

## Test plan
- Reset release with memory word at 0x4000_0000 = 0x00500093:
  - cycle 0: `inst_valid` = 0, `inst` = 0x13;
  - cycle 1: `inst` = 0x00500093, `inst_pc` = 0x4000_0000;
  - cycle 2: `inst_pc` = 0x4000_0004.
- Redirect with `alu_out` = 0x4000_0103 in cycle t → `imem_addr` = 0x4000_0100 in cycle t; `inst_pc` = 0x4000_0100 in t+1.
- Stall held 3 cycles at `inst_pc` = 0x4000_0008:
  - `inst`/`inst_pc` constant and `fetch_count` frozen;
  - after release, `inst_pc` = 0x4000_000C one cycle later.
- Redirect to 0x4000_0200 during stall, then redirect to 0x4000_0300 while still stalled:
  - bubble throughout the stall;
  - after the stall drops, `inst_pc` = 0x4000_0300.
- `inst_kill` pulse for 1 cycle → `inst` = 0x13 and `inst_valid` = 0 that cycle, PC sequence unaffected, `fetch_count` not incremented.
- `reset` asserted mid-REDIR_PEND → outputs return to reset values immediately; after release, fetch restarts at 0x4000_0000 and `fetch_count` = 0.
